// File: rtl/branch_seq_if.sv
// branch_seq_if: control-unit <-> PC-update sequencer signal bundle
interface branch_seq_if #(parameter int CNT_W = 16);
  logic             start;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             Zero;
  logic             Gt;
  logic             busy;
  logic             done;
  logic             illegal;
  logic             branch_taken;
  logic             PCWrite;
  logic             PCWriteCond;
  logic [1:0]       EQorNE;
  logic [1:0]       GTorLT;
  logic [1:0]       PCSource;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOp;
  logic             link_we;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] ntaken_cnt;
  modport master (
    output start, opcode, funct, Zero, Gt,
    input  busy, done, illegal, branch_taken, PCWrite, PCWriteCond, EQorNE, GTorLT,
           PCSource, ALUSrcA, ALUSrcB, ALUOp, link_we, taken_cnt, ntaken_cnt
  );
  modport slave (
    input  start, opcode, funct, Zero, Gt,
    output busy, done, illegal, branch_taken, PCWrite, PCWriteCond, EQorNE, GTorLT,
           PCSource, ALUSrcA, ALUSrcB, ALUOp, link_we, taken_cnt, ntaken_cnt
  );
endinterface

// File: rtl/branch_seq.sv
// branch_seq: multicycle sequencer driving the PC-update path for branches and jumps
module branch_seq #(
  parameter int         CNT_W   = 16,
  parameter logic [2:0] ALU_SUB = 3'b010
) (
  input logic         clk,
  input logic         reset,
  branch_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMP, RESOLVE, LINK, JUMP, DONE} state_t;
  typedef enum logic [2:0] {K_NONE, K_BEQ, K_BNE, K_BLE, K_BGT, K_J, K_JAL, K_JR} kind_t;
  state_t state, state_n;
  kind_t dec, kind;
  logic accept, ill, taken, taken_q;
  logic [1:0] eq_sel, gt_sel;
  logic [CNT_W-1:0] tcnt, ncnt;
  assign dec = bus.opcode == 6'h04 ? K_BEQ :
               bus.opcode == 6'h05 ? K_BNE :
               bus.opcode == 6'h06 ? K_BLE :
               bus.opcode == 6'h07 ? K_BGT :
               bus.opcode == 6'h02 ? K_J   :
               bus.opcode == 6'h03 ? K_JAL :
               (bus.opcode == 6'h00 && bus.funct == 6'h08) ? K_JR : K_NONE;
  assign accept = state == IDLE && bus.start;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !accept || dec == K_NONE ? IDLE :
                         dec == K_JAL ? LINK :
                         (dec == K_J || dec == K_JR) ? JUMP : CMP;
      CMP:     state_n = RESOLVE;
      RESOLVE: state_n = DONE;
      LINK:    state_n = JUMP;
      JUMP:    state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // Selectors are only live in RESOLVE so the PC can never be written conditionally elsewhere
  assign eq_sel = state != RESOLVE ? 2'd0 : kind == K_BEQ ? 2'd2 : kind == K_BNE ? 2'd1 : 2'd0;
  assign gt_sel = state != RESOLVE ? 2'd0 : kind == K_BGT ? 2'd2 : kind == K_BLE ? 2'd1 : 2'd0;
  assign taken  = (eq_sel == 2'd2 && bus.Zero) || (eq_sel == 2'd1 && !bus.Zero) ||
                  (gt_sel == 2'd2 && bus.Gt)   || (gt_sel == 2'd1 && !bus.Gt);
  assign bus.busy         = state != IDLE;
  assign bus.done         = state == DONE;
  assign bus.illegal      = ill;
  assign bus.branch_taken = taken_q;
  assign bus.PCWrite      = state == JUMP;
  assign bus.PCWriteCond  = state == RESOLVE;
  assign bus.EQorNE       = eq_sel;
  assign bus.GTorLT       = gt_sel;
  assign bus.PCSource     = state == RESOLVE ? 2'd1 : state != JUMP ? 2'd0 : kind == K_JR ? 2'd3 : 2'd2;
  assign bus.ALUSrcA      = state == CMP || state == RESOLVE;
  assign bus.ALUSrcB      = 2'd0;
  assign bus.ALUOp        = (state == CMP || state == RESOLVE) ? ALU_SUB : 3'd0;
  assign bus.link_we      = state == LINK;
  assign bus.taken_cnt    = tcnt;
  assign bus.ntaken_cnt   = ncnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      kind    <= K_NONE;
      ill     <= 1'b0;
      taken_q <= 1'b0;
      tcnt    <= '0;
      ncnt    <= '0;
    end else begin
      state <= state_n;
      ill   <= accept && dec == K_NONE;
      if (accept) kind <= dec;
      if (state == JUMP) taken_q <= 1'b1;
      if (state == RESOLVE) begin
        taken_q <= taken;
        if (taken) tcnt <= tcnt + CNT_W'(tcnt != '1);
        else       ncnt <= ncnt + CNT_W'(ncnt != '1);
      end
    end
  end
endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: directed checks of branch_seq, plus a narrow-counter instance for saturation
module tb_branch_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  branch_seq_if #(.CNT_W(16)) m_if ();
  branch_seq_if #(.CNT_W(2))  s_if ();
  assign s_if.start  = m_if.start;
  assign s_if.opcode = m_if.opcode;
  assign s_if.funct  = m_if.funct;
  assign s_if.Zero   = m_if.Zero;
  assign s_if.Gt     = m_if.Gt;
  branch_seq #(.CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(m_if.slave));
  branch_seq #(.CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(s_if.slave));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [5:0] op, input logic [5:0] fn);
    m_if.start = 1'b1;
    m_if.opcode = op;
    m_if.funct = fn;
    step();
    m_if.start = 1'b0;
  endtask
  initial begin
    m_if.start = 1'b0;
    m_if.opcode = 6'h00;
    m_if.funct = 6'h00;
    m_if.Zero = 1'b0;
    m_if.Gt = 1'b0;
    step();
    step();
    chk("rst_busy", m_if.busy, 0);
    chk("rst_pcwc", m_if.PCWriteCond, 0);
    chk("rst_alua", m_if.ALUSrcA, 0);
    chk("rst_tcnt", m_if.taken_cnt, 0);
    reset = 1'b1;
    step();
    // beq taken
    go(6'h04, 6'h00);
    chk("beq_cmp_busy", m_if.busy, 1);
    chk("beq_cmp_alua", m_if.ALUSrcA, 1);
    chk("beq_cmp_aluop", m_if.ALUOp, 3'b010);
    chk("beq_cmp_pcwc", m_if.PCWriteCond, 0);
    m_if.Zero = 1'b1;
    step();
    chk("beq_res_pcwc", m_if.PCWriteCond, 1);
    chk("beq_res_eq", m_if.EQorNE, 2);
    chk("beq_res_gt", m_if.GTorLT, 0);
    chk("beq_res_pcsrc", m_if.PCSource, 1);
    chk("beq_res_done", m_if.done, 0);
    step();
    chk("beq_done", m_if.done, 1);
    chk("beq_taken", m_if.branch_taken, 1);
    chk("beq_tcnt", m_if.taken_cnt, 1);
    chk("beq_done_pcwc", m_if.PCWriteCond, 0);
    step();
    chk("beq_idle_busy", m_if.busy, 0);
    chk("beq_idle_done", m_if.done, 0);
    // bne not taken, with starts while busy and in DONE
    go(6'h05, 6'h00);
    m_if.start = 1'b1;
    m_if.opcode = 6'h02;
    step();
    m_if.start = 1'b0;
    chk("bne_res_eq", m_if.EQorNE, 1);
    chk("bne_res_pcw", m_if.PCWrite, 0);
    m_if.start = 1'b1;
    step();
    chk("bne_done", m_if.done, 1);
    chk("bne_taken", m_if.branch_taken, 0);
    chk("bne_ncnt", m_if.ntaken_cnt, 1);
    step();
    m_if.start = 1'b0;
    chk("busy_start_ign", m_if.busy, 0);
    chk("busy_start_pcw", m_if.PCWrite, 0);
    // ble with Gt=0 taken, bgt with Gt=0 not taken
    m_if.Gt = 1'b0;
    go(6'h06, 6'h00);
    step();
    chk("ble_res_gt", m_if.GTorLT, 1);
    chk("ble_res_eq", m_if.EQorNE, 0);
    step();
    chk("ble_taken", m_if.branch_taken, 1);
    chk("ble_tcnt", m_if.taken_cnt, 2);
    step();
    go(6'h07, 6'h00);
    step();
    chk("bgt_res_gt", m_if.GTorLT, 2);
    step();
    chk("bgt_taken", m_if.branch_taken, 0);
    chk("bgt_ncnt", m_if.ntaken_cnt, 2);
    step();
    // jal
    go(6'h03, 6'h00);
    chk("jal_link", m_if.link_we, 1);
    chk("jal_link_pcw", m_if.PCWrite, 0);
    step();
    chk("jal_pcw", m_if.PCWrite, 1);
    chk("jal_pcsrc", m_if.PCSource, 2);
    chk("jal_link_off", m_if.link_we, 0);
    step();
    chk("jal_done", m_if.done, 1);
    chk("jal_taken", m_if.branch_taken, 1);
    chk("jal_tcnt", m_if.taken_cnt, 2);
    step();
    // jr, then j
    go(6'h00, 6'h08);
    chk("jr_pcw", m_if.PCWrite, 1);
    chk("jr_pcsrc", m_if.PCSource, 3);
    step();
    chk("jr_done", m_if.done, 1);
    step();
    go(6'h02, 6'h00);
    chk("j_pcsrc", m_if.PCSource, 2);
    step();
    chk("j_done", m_if.done, 1);
    step();
    // illegal ops
    go(6'h3F, 6'h00);
    chk("ill_pulse", m_if.illegal, 1);
    chk("ill_busy", m_if.busy, 0);
    step();
    chk("ill_clear", m_if.illegal, 0);
    go(6'h00, 6'h00);
    chk("ill_funct", m_if.illegal, 1);
    step();
    // two more taken beqs saturate the 2-bit counter at 3
    m_if.Zero = 1'b1;
    go(6'h04, 6'h00);
    step();
    step();
    chk("sat_s_tcnt3", s_if.taken_cnt, 3);
    step();
    go(6'h04, 6'h00);
    step();
    step();
    chk("sat_s_hold", s_if.taken_cnt, 3);
    chk("sat_m_tcnt", m_if.taken_cnt, 4);
    chk("sat_s_ncnt", s_if.ntaken_cnt, 2);
    step();
    // asynchronous reset in RESOLVE
    go(6'h04, 6'h00);
    step();
    chk("ar_pre_pcwc", m_if.PCWriteCond, 1);
    #1 reset = 1'b0;
    #1;
    chk("ar_pcwc", m_if.PCWriteCond, 0);
    chk("ar_busy", m_if.busy, 0);
    chk("ar_eq", m_if.EQorNE, 0);
    chk("ar_alua", m_if.ALUSrcA, 0);
    chk("ar_taken", m_if.branch_taken, 0);
    chk("ar_tcnt", m_if.taken_cnt, 0);
    #1 reset = 1'b1;
    step();
    chk("ar_idle", m_if.busy, 0);
    chk("ar_done", m_if.done, 0);
    go(6'h02, 6'h00);
    chk("ar_recover", m_if.PCWrite, 1);
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
